wavetable_reader: RTL
=====================

# wavetable_reader

Read-side client of `wavetable_ram`, the counterpart to the wavetable loader that fills it. On a start request for a voice and wavetable position, it fetches the entry at the requested index and the following entry (wrapping at the table end). It returns the waveform pair from the first entry and a factor linearly interpolated between the two entries. It sits between the per-voice sample sequencer and the oscillator mixer, and drives the RAM read port (`re`, `addr_r`, `waveform_left_r`, `waveform_right_r`, `factor_r`).

## Interface

- `RAM_SIZE`, 61: number of valid RAM entries; valid indices are 0..RAM_SIZE-1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; sampled only when `ready`=1.
- `voice_num`  in  4  voice tag, carried through to `out_voice`.
- `index`  in  6  first entry index.
- `frac`  in  8  interpolation fraction between entry `index` and the next entry, 0..255/256.
- `ready`  out  1  high in IDLE only.
- `ram_re`  out  1  RAM read enable.
- `ram_addr_r`  out  6  RAM read address.
- `ram_wfm_l_r`  in  8  RAM left waveform id, valid the cycle after `ram_re`.
- `ram_wfm_r_r`  in  8  RAM right waveform id, same timing.
- `ram_factor_r`  in  8  RAM crossfade factor, same timing.
- `out_valid`  out  1  one-cycle result strobe.
- `out_err`  out  1  qualifies `out_valid`; set when `index` ≥ RAM_SIZE.
- `out_voice`  out  4  latched `voice_num`.
- `out_wfm_l`  out  8  left waveform id of entry `index`.
- `out_wfm_r`  out  8  right waveform id of entry `index`.
- `out_factor`  out  8  interpolated factor.

## Operation

- FSM states: IDLE, RD0, RD1, CAP1, CALC, DONE.
- IDLE
  - `ready`=1.
  - On `start`, latch `voice_num`, `index` and `frac`.
  - If `index` < RAM_SIZE, go to RD0; otherwise go to DONE with the error flag set.
- RD0: `ram_re`=1, `ram_addr_r`=idx.
- RD1
  - Capture wfm_l, wfm_r and factor as f0 from the RAM bus.
  - `ram_re`=1, `ram_addr_r`=idx_next.
  - idx_next = 0 if idx = RAM_SIZE-1, else idx+1.
- CAP1: capture f1 from the RAM bus; `ram_re`=0.
- CALC
  - d = f1 − f0, as a 9-bit signed value.
  - p = d × frac, as a 17-bit signed value.
  - out_factor = f0 + (p >>> 8), arithmetic shift, so the result rounds toward −∞.
  - The result is always within 0..255; no saturation logic.
- DONE
  - `out_valid`=1 for exactly one cycle, then return to IDLE.
  - On the error path: `out_err`=1 and `out_wfm_l`, `out_wfm_r`, `out_factor` are 0. No RAM access occurs.
- Output holding:
  - `out_*` data outputs hold their values until the next DONE.
  - `out_err` is cleared on any non-error DONE.
- `start` outside IDLE is ignored and not queued.
- `ram_re`=0 and `ram_addr_r`=0 in every state except RD0 and RD1.
- Reset, asserted at any time, including mid-fetch:
  - State returns to IDLE.
  - All outputs go to 0 except `ready`, which is 1 once `rst_n` is high.
  - Latched request and captured data registers are zeroed.
  - An aborted request produces no `out_valid`.

## Timing

- Start sampled at edge N. The following cycles are counted as "after edge N+k":
  - After N: RD0, with `ram_re`=1.
  - After N+1: RD1, RAM data for idx present; f0 captured at edge N+2.
  - After N+2: CAP1; f1 captured at edge N+3.
  - After N+3: CALC; result registered at edge N+4.
  - After N+4: DONE, `out_valid`=1.
  - After N+5: IDLE, `ready`=1.
- Valid-index latency from start to `out_valid` is 5 cycles; sustained throughput is 1 request per 6 cycles.
- Error path: DONE follows immediately after N (latency 1), and `ready` returns after N+1.
- `ready` is 0 from the cycle after the accepting edge until IDLE is re-entered.
- RAM read latency is exactly 1 cycle. Concurrent RAM writes from the loader are not arbitrated here; the sequencer must not issue requests while a load is in progress.

## Test plan

- Reset check: hold `rst_n`=0 mid-RD1, then release → all outputs 0, `ready`=1, no `out_valid`. A new start then completes normally.
- Entry 5 = {l=0x03, r=0x07, f=0x40}, entry 6 f=0xC0; start idx=5, frac=0x80 → `out_valid` 5 cycles later with l=0x03, r=0x07, factor=0x80, voice echoed, `out_err`=0.
- Entry 10 f=0xC0, entry 11 f=0x40, frac=0x80 → factor 0x80 (negative slope). Repeat with frac=0x00 → factor 0xC0.
- Entry 0 f=0x00, entry 1 f=0xFF, frac=0xFF → factor 0xFE. Confirm `ram_addr_r` sequence is 0, 1.
- Wrap: idx=60, entry 60 f=0x10, entry 0 f=0x30, frac=0x80 → addresses 60 then 0, factor=0x20.
- Error and ignore:
  - Start with idx=61 → `out_valid` with `out_err`=1 and zero data after 1 cycle, with no `ram_re` pulse.
  - A second `start` issued during RD1 of a valid request is ignored: exactly one `out_valid` is produced.

Source files
------------

// File: rtl/wavetable_reader.sv
`default_nettype none
// ============================================================================
// Module   : wavetable_reader
// Purpose  : Read-side client of the wavetable RAM. For each request it
//            fetches entry `index` and the following entry (wrapping at the
//            table end). It returns the waveform pair of the first entry and
//            a crossfade factor linearly interpolated between both entries.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start_i        in   request pulse, sampled only while ready_o=1
//   voice_num_i    in   [3:0] voice tag, echoed on out_voice_o
//   index_i        in   [5:0] first entry index
//   frac_i         in   [7:0] interpolation fraction (x/256)
//   ready_o        out  high in IDLE only
//   ram_re_o       out  RAM read enable
//   ram_addr_r_o   out  [5:0] RAM read address
//   ram_wfm_l_r_i  in   [7:0] RAM left waveform id (1-cycle read latency)
//   ram_wfm_r_r_i  in   [7:0] RAM right waveform id
//   ram_factor_r_i in   [7:0] RAM crossfade factor
//   out_valid_o    out  one-cycle result strobe
//   out_err_o      out  request index was out of range
//   out_voice_o    out  [3:0] latched voice tag
//   out_wfm_l_o    out  [7:0] left waveform id of entry `index`
//   out_wfm_r_o    out  [7:0] right waveform id of entry `index`
//   out_factor_o   out  [7:0] interpolated factor
// ============================================================================
module wavetable_reader #(
  parameter int RAM_SIZE = 61
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [3:0] voice_num_i,
  input  logic [5:0] index_i,
  input  logic [7:0] frac_i,
  output logic       ready_o,
  output logic       ram_re_o,
  output logic [5:0] ram_addr_r_o,
  input  logic [7:0] ram_wfm_l_r_i,
  input  logic [7:0] ram_wfm_r_r_i,
  input  logic [7:0] ram_factor_r_i,
  output logic       out_valid_o,
  output logic       out_err_o,
  output logic [3:0] out_voice_o,
  output logic [7:0] out_wfm_l_o,
  output logic [7:0] out_wfm_r_o,
  output logic [7:0] out_factor_o
);

  localparam logic [6:0] c_ram_size = 7'(RAM_SIZE);
  localparam logic [5:0] c_last_idx = 6'(RAM_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_CAP1 = 3'd3,
    S_CALC = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e     state_q, state_d;

  logic [3:0] voice_q;
  logic [5:0] idx_q;
  logic [7:0] frac_q;
  logic [7:0] wfm_l_q, wfm_r_q;
  logic [7:0] f0_q, f1_q;

  logic       out_err_q;
  logic [3:0] out_voice_q;
  logic [7:0] out_wfm_l_q, out_wfm_r_q, out_factor_q;

  logic              idx_ok;
  logic [5:0]        idx_next;
  logic signed [8:0] diff;
  logic signed [16:0] diff_x, frac_x, prod;
  logic signed [9:0] interp;

  assign idx_ok   = ({1'b0, index_i} < c_ram_size);
  assign idx_next = (idx_q == c_last_idx) ? 6'd0 : idx_q + 6'd1;

  // Slope f1 - f0 spans -255..255, product with frac spans -65025..65025,
  // both fit the signed widths below. The arithmetic shift floors the
  // scaled slope, so the sum stays within 0..255 by construction.
  assign diff   = $signed({1'b0, f1_q}) - $signed({1'b0, f0_q});
  assign diff_x = 17'(diff);
  assign frac_x = {9'd0, frac_q};
  assign prod   = diff_x * frac_x;
  assign interp = $signed({2'b00, f0_q}) + 10'(prod >>> 8);

  // Next-state and RAM port decode
  always_comb begin
    state_d      = state_q;
    ram_re_o     = 1'b0;
    ram_addr_r_o = 6'd0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = idx_ok ? S_RD0 : S_DONE;
        end
      end
      S_RD0: begin
        ram_re_o     = 1'b1;
        ram_addr_r_o = idx_q;
        state_d      = S_RD1;
      end
      S_RD1: begin
        ram_re_o     = 1'b1;
        ram_addr_r_o = idx_next;
        state_d      = S_CAP1;
      end
      S_CAP1:  state_d = S_CALC;
      S_CALC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      voice_q      <= 4'd0;
      idx_q        <= 6'd0;
      frac_q       <= 8'd0;
      wfm_l_q      <= 8'd0;
      wfm_r_q      <= 8'd0;
      f0_q         <= 8'd0;
      f1_q         <= 8'd0;
      out_err_q    <= 1'b0;
      out_voice_q  <= 4'd0;
      out_wfm_l_q  <= 8'd0;
      out_wfm_r_q  <= 8'd0;
      out_factor_q <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            voice_q <= voice_num_i;
            idx_q   <= index_i;
            frac_q  <= frac_i;
            // Error results are published directly on the way to DONE.
            if (!idx_ok) begin
              out_err_q    <= 1'b1;
              out_voice_q  <= voice_num_i;
              out_wfm_l_q  <= 8'd0;
              out_wfm_r_q  <= 8'd0;
              out_factor_q <= 8'd0;
            end
          end
        end
        S_RD1: begin
          wfm_l_q <= ram_wfm_l_r_i;
          wfm_r_q <= ram_wfm_r_r_i;
          f0_q    <= ram_factor_r_i;
        end
        S_CAP1: begin
          f1_q <= ram_factor_r_i;
        end
        S_CALC: begin
          out_err_q    <= 1'b0;
          out_voice_q  <= voice_q;
          out_wfm_l_q  <= wfm_l_q;
          out_wfm_r_q  <= wfm_r_q;
          out_factor_q <= interp[7:0];
        end
        default: ;
      endcase
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign out_valid_o  = (state_q == S_DONE);
  assign out_err_o    = out_err_q;
  assign out_voice_o  = out_voice_q;
  assign out_wfm_l_o  = out_wfm_l_q;
  assign out_wfm_r_o  = out_wfm_r_q;
  assign out_factor_o = out_factor_q;

endmodule
`default_nettype wire
